// File: rtl/sme_load_ctrl.sv
// sme_load_ctrl: front-end sequencer for the string-matching engine.
// Parses the serial isstring/ispattern/chardata stream into the string and
// pattern buffers, kicks the matcher, and presents its result on valid.
module sme_load_ctrl #(
    parameter int DW      = 8,
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          isstring,
    input  logic          ispattern,
    input  logic [DW-1:0] chardata,
    output logic          str_we,
    output logic [5:0]    str_addr,
    output logic [DW-1:0] str_wdata,
    output logic [5:0]    str_len,
    output logic          pat_we,
    output logic [3:0]    pat_addr,
    output logic [DW-1:0] pat_wdata,
    output logic [3:0]    pat_len,
    output logic          mat_start,
    input  logic          mat_done,
    input  logic          mat_hit,
    input  logic [4:0]    mat_index,
    output logic          match,
    output logic [4:0]    match_index,
    output logic          valid,
    output logic          busy
);

    localparam logic [5:0] STR_LIM = 6'(STR_MAX);
    localparam logic [3:0] PAT_LIM = 4'(PAT_MAX);

    typedef enum logic [2:0] {
        IDLE,
        S_LOAD,
        P_LOAD,
        START,
        WAIT,
        OUT
    } state_t;

    state_t     state;
    logic [5:0] scnt;
    logic [3:0] pcnt;

    // Sequencer: load string/pattern, launch matcher, emit one result strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            scnt        <= '0;
            pcnt        <= '0;
            str_we      <= 1'b0;
            str_addr    <= '0;
            str_wdata   <= '0;
            str_len     <= '0;
            pat_we      <= 1'b0;
            pat_addr    <= '0;
            pat_wdata   <= '0;
            pat_len     <= '0;
            mat_start   <= 1'b0;
            match       <= 1'b0;
            match_index <= '0;
            valid       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // Strobes last exactly one cycle unless re-asserted below.
            str_we      <= 1'b0;
            pat_we      <= 1'b0;
            mat_start   <= 1'b0;
            valid       <= 1'b0;
            match       <= 1'b0;
            match_index <= '0;
            case (state)
                IDLE: begin
                    if (isstring) begin
                        str_we    <= 1'b1;
                        str_addr  <= '0;
                        str_wdata <= chardata;
                        scnt      <= 6'd1;
                        state     <= S_LOAD;
                    end else if (ispattern) begin
                        // Pattern-only job: the previously loaded string is reused.
                        pat_we    <= 1'b1;
                        pat_addr  <= '0;
                        pat_wdata <= chardata;
                        pcnt      <= 4'd1;
                        state     <= P_LOAD;
                    end
                end
                S_LOAD: begin
                    if (isstring) begin
                        // Characters beyond the buffer depth are silently dropped.
                        if (scnt < STR_LIM) begin
                            str_we    <= 1'b1;
                            str_addr  <= scnt;
                            str_wdata <= chardata;
                            scnt      <= scnt + 6'd1;
                        end
                    end else begin
                        str_len <= scnt;
                        if (ispattern) begin
                            pat_we    <= 1'b1;
                            pat_addr  <= '0;
                            pat_wdata <= chardata;
                            pcnt      <= 4'd1;
                            state     <= P_LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                P_LOAD: begin
                    if (ispattern) begin
                        if (pcnt < PAT_LIM) begin
                            pat_we    <= 1'b1;
                            pat_addr  <= pcnt;
                            pat_wdata <= chardata;
                            pcnt      <= pcnt + 4'd1;
                        end
                    end else begin
                        pat_len <= pcnt;
                        busy    <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    // A pattern that cannot fit in the string can never match.
                    if (str_len == 6'd0 || {2'b00, pat_len} > str_len) begin
                        valid <= 1'b1;
                        state <= OUT;
                    end else begin
                        mat_start <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (mat_done) begin
                        valid       <= 1'b1;
                        match       <= mat_hit;
                        match_index <= mat_hit ? mat_index : 5'd0;
                        state       <= OUT;
                    end
                end
                OUT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sme_load_ctrl.sv
// tb_sme_load_ctrl: scoreboard bench for sme_load_ctrl with directed jobs.
module tb_sme_load_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       isstring, ispattern;
    logic [7:0] chardata;
    logic       str_we, pat_we, mat_start, match, valid, busy;
    logic [5:0] str_addr, str_len;
    logic [7:0] str_wdata, pat_wdata;
    logic [3:0] pat_addr, pat_len;
    logic       mat_done, mat_hit;
    logic [4:0] mat_index, match_index;

    int checks = 0;
    int errors = 0;
    int nstarts = 0;
    int exp_starts = 0;

    logic [13:0] sq[$];
    logic [11:0] pq[$];
    logic [5:0]  rq[$];

    sme_load_ctrl #(.DW(8), .STR_MAX(32), .PAT_MAX(8)) dut (
        .clk(clk), .rst(rst), .isstring(isstring), .ispattern(ispattern),
        .chardata(chardata), .str_we(str_we), .str_addr(str_addr),
        .str_wdata(str_wdata), .str_len(str_len), .pat_we(pat_we),
        .pat_addr(pat_addr), .pat_wdata(pat_wdata), .pat_len(pat_len),
        .mat_start(mat_start), .mat_done(mat_done), .mat_hit(mat_hit),
        .mat_index(mat_index), .match(match), .match_index(match_index),
        .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Monitor: pop and compare whenever the DUT presents a write or a result.
    always @(negedge clk) begin
        logic [13:0] es;
        logic [11:0] ep;
        logic [5:0]  er;
        if (mat_start) nstarts++;
        if (str_we) begin
            checks++;
            if (sq.size() == 0) begin
                errors++;
                $display("FAIL str_wr unexpected addr=%0d data=%h", str_addr, str_wdata);
            end else begin
                es = sq.pop_front();
                if ({str_addr, str_wdata} !== es) begin
                    errors++;
                    $display("FAIL str_wr got addr=%0d data=%h want addr=%0d data=%h",
                             str_addr, str_wdata, es[13:8], es[7:0]);
                end
            end
        end
        if (pat_we) begin
            checks++;
            if (pq.size() == 0) begin
                errors++;
                $display("FAIL pat_wr unexpected addr=%0d data=%h", pat_addr, pat_wdata);
            end else begin
                ep = pq.pop_front();
                if ({pat_addr, pat_wdata} !== ep) begin
                    errors++;
                    $display("FAIL pat_wr got addr=%0d data=%h want addr=%0d data=%h",
                             pat_addr, pat_wdata, ep[11:8], ep[7:0]);
                end
            end
        end
        if (valid) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL result unexpected match=%0d idx=%0d", match, match_index);
            end else begin
                er = rq.pop_front();
                if ({match, match_index} !== er) begin
                    errors++;
                    $display("FAIL result got match=%0d idx=%0d want match=%0d idx=%0d",
                             match, match_index, er[5], er[4:0]);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic is, input logic ip, input logic [7:0] d);
        isstring  = is;
        ispattern = ip;
        chardata  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_str(input int a, input logic [7:0] d);
        sq.push_back({6'(a), d});
    endtask

    task automatic exp_pat(input int a, input logic [7:0] d);
        pq.push_back({4'(a), d});
    endtask

    task automatic wait_start();
        int n = 0;
        while (!mat_start && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!mat_start) begin
            errors++;
            $display("FAIL wait_start got 0 want 1");
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL wait_idle busy got 1 want 0");
        end
    endtask

    // Matcher model: answer once mat_start has been seen.
    task automatic answer(input logic hit, input logic [4:0] idx);
        wait_start();
        mat_done  = 1'b1;
        mat_hit   = hit;
        mat_index = idx;
        drive(1'b0, 1'b0, 8'h00);
        mat_done  = 1'b0;
        mat_hit   = 1'b0;
        mat_index = '0;
    endtask

    initial begin
        rst = 1'b1; isstring = 0; ispattern = 0; chardata = 0;
        mat_done = 0; mat_hit = 0; mat_index = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_str_len", int'(str_len), 0);
        check("rst_pat_len", int'(pat_len), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_outs", int'({str_we, pat_we, mat_start, match, match_index}), 0);

        // Job 1: "ABCD" then "BC", hit at 1
        exp_str(0, "A"); exp_str(1, "B"); exp_str(2, "C"); exp_str(3, "D");
        exp_pat(0, "B"); exp_pat(1, "C");
        rq.push_back({1'b1, 5'd1});
        drive(1, 0, "A"); drive(1, 0, "B"); drive(1, 0, "C"); drive(1, 0, "D");
        drive(0, 1, "B"); drive(0, 1, "C"); drive(0, 0, 8'h00);
        check("j1_busy_start", int'(busy), 1);
        exp_starts++;
        answer(1'b1, 5'd1);
        wait_idle();
        check("j1_str_len", int'(str_len), 4);
        check("j1_pat_len", int'(pat_len), 2);
        check("j1_starts", nstarts, exp_starts);

        // Job 2: pattern "XY" only, miss with nonzero index from matcher
        exp_pat(0, "X"); exp_pat(1, "Y");
        rq.push_back({1'b0, 5'd0});
        drive(0, 1, "X"); drive(0, 1, "Y"); drive(0, 0, 8'h00);
        exp_starts++;
        answer(1'b0, 5'd3);
        wait_idle();
        check("j2_str_len", int'(str_len), 4);
        check("j2_pat_len", int'(pat_len), 2);
        check("j2_starts", nstarts, exp_starts);

        // Job 3: 40-char string, 10-char pattern, saturating lengths
        for (int i = 0; i < 32; i++) exp_str(i, 8'(8'h20 + i));
        for (int i = 0; i < 8; i++) exp_pat(i, 8'(8'h60 + i));
        rq.push_back({1'b1, 5'd24});
        for (int i = 0; i < 40; i++) drive(1, 0, 8'(8'h20 + i));
        for (int i = 0; i < 10; i++) drive(0, 1, 8'(8'h60 + i));
        drive(0, 0, 8'h00);
        exp_starts++;
        answer(1'b1, 5'd24);
        wait_idle();
        check("j3_str_len", int'(str_len), 32);
        check("j3_pat_len", int'(pat_len), 8);
        check("j3_starts", nstarts, exp_starts);

        // Job 4: reset while waiting for the matcher
        exp_pat(0, "Q");
        drive(0, 1, "Q"); drive(0, 0, 8'h00);
        exp_starts++;
        wait_start();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("j4_busy", int'(busy), 0);
        check("j4_str_len", int'(str_len), 0);
        check("j4_pat_len", int'(pat_len), 0);
        check("j4_outs", int'({str_we, pat_we, mat_start, valid, match, match_index}), 0);
        mat_done = 1'b1; mat_hit = 1'b1; mat_index = 5'd7;
        repeat (3) drive(0, 0, 8'h00);
        mat_done = 1'b0; mat_hit = 1'b0; mat_index = '0;
        check("j4_busy_after", int'(busy), 0);
        check("j4_starts", nstarts, exp_starts);

        // Job 5: both flags high -> string only; pattern longer than string
        exp_str(0, "A"); exp_str(1, "B");
        exp_pat(0, "A"); exp_pat(1, "B"); exp_pat(2, "C");
        rq.push_back({1'b0, 5'd0});
        drive(1, 1, "A"); drive(1, 1, "B");
        drive(0, 1, "A"); drive(0, 1, "B"); drive(0, 1, "C"); drive(0, 0, 8'h00);
        wait_idle();
        check("j5_str_len", int'(str_len), 2);
        check("j5_pat_len", int'(pat_len), 3);
        check("j5_no_start", nstarts, exp_starts);

        // Job 6: mat_done held from START, chars driven while busy
        exp_pat(0, "A");
        rq.push_back({1'b1, 5'd1});
        drive(0, 1, "A");
        mat_done = 1'b1; mat_hit = 1'b1; mat_index = 5'd1;
        drive(0, 0, 8'h00);
        exp_starts++;
        drive(1, 1, "Z");
        drive(1, 1, "Z");
        check("j6_valid_out", int'(valid), 1);
        drive(0, 0, 8'h00);
        mat_done = 1'b0; mat_hit = 1'b0; mat_index = '0;
        // Back-to-back: string char right after OUT is accepted from IDLE
        exp_str(0, "K");
        drive(1, 0, "K"); drive(0, 0, 8'h00);
        check("j6_busy", int'(busy), 0);
        check("j6_starts", nstarts, exp_starts);
        check("b2b_str_len", int'(str_len), 1);
        check("j6_pat_len", int'(pat_len), 1);

        repeat (3) @(posedge clk);
        #1;
        check("sq_empty", sq.size(), 0);
        check("pq_empty", pq.size(), 0);
        check("rq_empty", rq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
